dmem_sized_port: RTL and testbench
==================================

// Module: dmem_sized_port
// PURPOSE
//  Parametrised data memory for the pipelined MIPS MEM stage, successor to the flat word memory.
//  - Byte/half/word loads and stores, little-endian lanes, sign/zero-extended loads.
//  - Misalignment detection; programmable wait states behind a valid/ready handshake so the pipeline can stall.
// PARAMETERS
//  ADDR_W    10  word-address bits; depth = 2**ADDR_W words of 32 bits
//  LATENCY    0  wait cycles inserted before the access commits (0..15)
// PORTS
//  clk        in   1         rising-edge clock
//  rst_n      in   1         asynchronous, active-low reset
//  req_valid  in   1         request present
//  req_ready  out  1         block can accept a request this cycle
//  req_we     in   1         1 = store, 0 = load
//  req_size   in   2         0 byte, 1 half, 2 word, 3 illegal
//  req_signed in   1         loads: 1 sign-extend, 0 zero-extend
//  req_addr   in   ADDR_W+2  byte address
//  req_wdata  in   32        store data, right-justified (byte in [7:0], half in [15:0])
//  rsp_valid  out  1         one-cycle pulse: request completed
//  rsp_rdata  out  32        load result (0 for stores and errors)
//  rsp_err    out  1         request misaligned/illegal; valid only with rsp_valid
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter 0.
//    Memory array is not reset.
//  - FSM states and transitions:
//    - IDLE: req_ready=1; on req_valid latch we/size/signed/addr/wdata.
//      LATENCY=0 -> access at the same edge -> RESP; else counter:=LATENCY -> WAIT.
//    - WAIT: req_ready=0; counter decrements each edge; at the edge where counter==1 perform access -> RESP.
//    - RESP: req_ready=0; rsp_valid=1 for exactly one cycle -> IDLE. Back-to-back requests therefore
//      cost LATENCY+2 cycles each; rsp_valid rises LATENCY+1 cycles after the accept cycle.
//  - Access (at commit edge):
//    - Error when size==3, size==1 with addr[0]=1, or size==2 with addr[1:0]!=0.
//      Error: no memory write, rsp_err=1, rsp_rdata=0.
//    - Store: word index addr[ADDR_W+1:2]. Byte enables: byte -> lane addr[1:0]; half -> lanes {addr[1],0},{addr[1],1};
//      word -> all. Data replicated into the lanes; only enabled lanes change. rsp_rdata=0.
//    - Load: read word, select lane(s) as for stores, extend to 32 bits per req_signed; size 2 ignores req_signed.
//  - Request inputs are sampled only in the IDLE accept cycle; later changes are ignored.
//    req_valid outside IDLE is ignored: no queueing.
//  - rsp_rdata/rsp_err hold their value after RESP until the next commit.
//  - Reset mid-operation: a request still in WAIT is dropped with no write. A write committed before reset persists.
//  - A load issued after a store to the same word observes the stored data (the store commits before the load is accepted).
// STRUCTURE
//  - Package dmem_pkg:
//    - size encodings SZ_BYTE=2'd0, SZ_HALF=2'd1, SZ_WORD=2'd2
//    - FSM state encoding IDLE/WAIT/RESP
//    - function computing the misalignment flag
//  - Sub-module dmem_lane_align (combinational):
//    - store path: size, addr[1:0], wdata -> 4-bit byte enable and lane-replicated write word
//    - load path: size, signed, addr[1:0], read word -> extended result
//  - Top: FSM, wait counter, request latch, 2**ADDR_W x 32 array with per-byte write.
// TESTING
//  1. LATENCY=0: SW 0x0000_0010 <= 0xDEADBEEF, then LW 0x10 -> rsp_valid 1 cycle after accept, rdata 0xDEADBEEF, err 0.
//  2. SB 0x13 <= 0x80, then LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LW 0x10 -> 0x80ADBEEF.
//  3. SH 0x12 <= 0x1234, then LH 0x12 -> 0x00001234; LW 0x10 -> 0x1234BEEF. SH 0x11 -> err=1, word unchanged.
//  4. LATENCY=3: LW accepted in cycle 0 -> req_ready low cycles 1-4, rsp_valid only in cycle 4;
//     req_valid held high is accepted again in cycle 5.
//  5. LATENCY=3: SW 0x20 <= 0x55, assert rst_n=0 in WAIT -> outputs at reset values immediately;
//     after release, LW 0x20 returns the prior content (preloaded 0x0), not 0x55.
//  6. Write top word (addr all ones & ~3) <= 0xA5A5A5A5, read back 0xA5A5A5A5; size=3 request -> err=1, rdata 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the sized data-memory port: access sizes, FSM states
// and the alignment rule used to flag bad requests.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmemState;

  // Size 3 is reserved and always rejected.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addrLo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addrLo[0];
      SZ_WORD: return (addrLo != 2'd0);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: byte enables and replicated store data on the
// way in, lane selection plus sign/zero extension on the way out.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        isSigned,
  input  logic [1:0]  addrLo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byteEn,
  output logic [31:0] wword,
  output logic [31:0] loadData
);

  logic [7:0]  rByte;
  logic [15:0] rHalf;

  assign rByte = rword[{addrLo, 3'b000} +: 8];
  assign rHalf = rword[{addrLo[1], 4'b0000} +: 16];

  always_comb begin
    byteEn   = 4'b0000;
    wword    = wdata;
    loadData = 32'd0;
    case (size)
      SZ_BYTE: begin
        byteEn   = 4'b0001 << addrLo;
        wword    = {4{wdata[7:0]}};
        loadData = {{24{isSigned & rByte[7]}}, rByte};
      end
      SZ_HALF: begin
        byteEn   = addrLo[1] ? 4'b1100 : 4'b0011;
        wword    = {2{wdata[15:0]}};
        loadData = {{16{isSigned & rHalf[15]}}, rHalf};
      end
      SZ_WORD: begin
        byteEn   = 4'b1111;
        loadData = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_sized_port.sv
// MEM-stage data memory with byte/half/word access, misalignment reporting
// and a programmable number of wait cycles before each access commits.
module dmem_sized_port
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output dmemState          dbgState
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, and rsp_valid pulses for one cycle per transfer.
  localparam int         DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] LAT   = 4'(LATENCY);

  logic [31:0]       mem [DEPTH];
  dmemState          state;
  logic [3:0]        waitCnt;
  logic              lWe, lSigned;
  logic [1:0]        lSize;
  logic [ADDR_W+1:0] lAddr;
  logic [31:0]       lWdata;

  logic              idle, curWe, curSigned, accErr, commit;
  logic [1:0]        curSize;
  logic [ADDR_W+1:0] curAddr;
  logic [ADDR_W-1:0] wordIdx;
  logic [31:0]       curWdata, rdWord, wrWord, loadData, rspData;
  logic [3:0]        byteEn;

  // With no wait states the access commits on the accept edge, so it must use
  // the live request rather than the latched copy.
  assign idle      = (state == IDLE);
  assign curWe     = idle ? req_we     : lWe;
  assign curSize   = idle ? req_size   : lSize;
  assign curSigned = idle ? req_signed : lSigned;
  assign curAddr   = idle ? req_addr   : lAddr;
  assign curWdata  = idle ? req_wdata  : lWdata;

  assign wordIdx  = curAddr[ADDR_W+1:2];
  assign rdWord   = mem[wordIdx];
  assign accErr   = misaligned(curSize, curAddr[1:0]);
  assign commit   = rst_n && ((idle && req_valid && (LATENCY == 0)) ||
                              (state == WAIT && waitCnt == 4'd1));
  assign rspData  = (curWe || accErr) ? 32'd0 : loadData;
  assign dbgState = state;

  dmem_lane_align u_align (
    .size     (curSize),
    .isSigned (curSigned),
    .addrLo   (curAddr[1:0]),
    .wdata    (curWdata),
    .rword    (rdWord),
    .byteEn   (byteEn),
    .wword    (wrWord),
    .loadData (loadData)
  );

  always_ff @(posedge clk) begin
    if (commit && curWe && !accErr) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) mem[wordIdx][8*b +: 8] <= wrWord[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      waitCnt   <= 4'd0;
      lWe       <= 1'b0;
      lSize     <= 2'd0;
      lSigned   <= 1'b0;
      lAddr     <= '0;
      lWdata    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lWe       <= req_we;
            lSize     <= req_size;
            lSigned   <= req_signed;
            lAddr     <= req_addr;
            lWdata    <= req_wdata;
            req_ready <= 1'b0;
            waitCnt   <= LAT;
            state     <= (LATENCY == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          waitCnt <= waitCnt - 4'd1;
          if (waitCnt == 4'd1) state <= RESP;
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
      rsp_valid <= commit;
      if (commit) begin
        rsp_rdata <= rspData;
        rsp_err   <= accErr;
      end
    end
  end

endmodule

// File: tb/tb_dmem_sized_port.sv
// Bench for dmem_sized_port: one instance with no wait states, one with three,
// each checked against a byte-array model of the memory.
module tb_dmem_sized_port;
  import dmem_pkg::*;

  localparam int AW    = 8;
  localparam int DEPTH = 2 ** AW;
  localparam int LAT0  = 0;
  localparam int LAT1  = 3;

  logic            clk;
  logic            rstN      [2];
  logic            reqValid  [2];
  logic            reqReady  [2];
  logic            reqWe     [2];
  logic [1:0]      reqSize   [2];
  logic            reqSigned [2];
  logic [AW+1:0]   reqAddr   [2];
  logic [31:0]     reqWdata  [2];
  logic            rspValid  [2];
  logic [31:0]     rspRdata  [2];
  logic            rspErr    [2];
  dmemState        dbg       [2];

  logic [7:0]      refB [2][4*DEPTH];
  logic [32:0]     exp_q [$];
  int              checks   = 0;
  int              failures = 0;

  dmem_sized_port #(.ADDR_W(AW), .LATENCY(LAT0)) dut0 (
    .clk(clk), .rst_n(rstN[0]), .req_valid(reqValid[0]), .req_ready(reqReady[0]),
    .req_we(reqWe[0]), .req_size(reqSize[0]), .req_signed(reqSigned[0]),
    .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]), .rsp_valid(rspValid[0]),
    .rsp_rdata(rspRdata[0]), .rsp_err(rspErr[0]), .dbgState(dbg[0])
  );

  dmem_sized_port #(.ADDR_W(AW), .LATENCY(LAT1)) dut1 (
    .clk(clk), .rst_n(rstN[1]), .req_valid(reqValid[1]), .req_ready(reqReady[1]),
    .req_we(reqWe[1]), .req_size(reqSize[1]), .req_signed(reqSigned[1]),
    .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]), .rsp_valid(rspValid[1]),
    .rsp_rdata(rspRdata[1]), .rsp_err(rspErr[1]), .dbgState(dbg[1])
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int latOf(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  // Reference: memory as a flat byte array, sizes as byte counts.
  task automatic modelAccess(input int d, input logic we, input logic [1:0] sz, input logic sg,
                             input logic [AW+1:0] addr, input logic [31:0] wd,
                             output logic [32:0] res);
    int n;
    logic [31:0] v;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    v = 32'd0;
    if (sz == 2'd3 || (int'(addr) % n) != 0) begin
      res = {1'b1, 32'd0};
    end else if (we) begin
      for (int k = 0; k < n; k++) refB[d][int'(addr) + k] = wd[8*k +: 8];
      res = 33'd0;
    end else begin
      for (int k = 0; k < n; k++) v[8*k +: 8] = refB[d][int'(addr) + k];
      if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      res = {1'b0, v};
    end
  endtask

  task automatic scramble(input int d);
    reqWe[d]     = 1'($urandom);
    reqSize[d]   = 2'($urandom);
    reqSigned[d] = 1'($urandom);
    reqAddr[d]   = (AW+2)'($urandom);
    reqWdata[d]  = $urandom;
  endtask

  // Driver: one request, response timing and value checked against the model.
  task automatic doReq(input int d, input logic we, input logic [1:0] sz, input logic sg,
                       input logic [AW+1:0] addr, input logic [31:0] wd,
                       output logic [32:0] rsp);
    logic [32:0] e;
    int n;
    modelAccess(d, we, sz, sg, addr, wd, e);
    exp_q.push_back(e);
    @(negedge clk);
    reqWe[d] = we; reqSize[d] = sz; reqSigned[d] = sg; reqAddr[d] = addr; reqWdata[d] = wd;
    reqValid[d] = 1'b1;
    n = 0;
    while (!reqReady[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkVal("ready_wait", 64'(reqReady[d]), 64'd1);
    @(posedge clk);
    #1;
    reqValid[d] = 1'b0;
    scramble(d);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rspValid[d] && n < 40);
    checkVal("rsp_latency", 64'(n), 64'(latOf(d) + 1));
    rsp = {rspErr[d], rspRdata[d]};
    e = exp_q.pop_front();
    checkVal("rsp_data", 64'(rsp), 64'(e));
    @(negedge clk);
    checkVal("rsp_pulse", 64'(rspValid[d]), 64'd0);
    checkVal("ready_back", 64'(reqReady[d]), 64'd1);
    checkVal("rsp_hold", 64'({rspErr[d], rspRdata[d]}), 64'(e));
  endtask

  task automatic checkResetOutputs(input int d, input string tag);
    checkVal({tag, "_ready"}, 64'(reqReady[d]), 64'd1);
    checkVal({tag, "_valid"}, 64'(rspValid[d]), 64'd0);
    checkVal({tag, "_rdata"}, 64'(rspRdata[d]), 64'd0);
    checkVal({tag, "_err"},   64'(rspErr[d]),   64'd0);
    checkVal({tag, "_state"}, 64'(dbg[d]),      64'(IDLE));
  endtask

  logic [32:0]   r;
  logic [AW+1:0] topAddr;

  initial begin
    for (int d = 0; d < 2; d++) begin
      rstN[d] = 1'b0;
      reqValid[d] = 1'b0;
      scramble(d);
    end
    topAddr = '1;
    topAddr[1:0] = 2'b00;
    repeat (3) @(negedge clk);
    checkResetOutputs(0, "reset0");
    checkResetOutputs(1, "reset1");
    rstN[0] = 1'b1;
    rstN[1] = 1'b1;

    // Zero the words the tests touch so the model starts from known content.
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 16; w++) doReq(d, 1'b1, SZ_WORD, 1'b0, (AW+2)'(4*w), 32'd0, r);
      doReq(d, 1'b1, SZ_WORD, 1'b0, topAddr, 32'd0, r);
    end

    // Word, byte and half traffic on the zero-wait instance.
    doReq(0, 1'b1, SZ_WORD, 1'b0, 'h10, 32'hDEADBEEF, r);
    doReq(0, 1'b0, SZ_WORD, 1'b0, 'h10, 32'h0, r);  checkVal("t1_lw", 64'(r), 64'h0_DEADBEEF);
    doReq(0, 1'b1, SZ_BYTE, 1'b0, 'h13, 32'h80, r);
    doReq(0, 1'b0, SZ_BYTE, 1'b1, 'h13, 32'h0, r);  checkVal("t2_lb", 64'(r), 64'h0_FFFFFF80);
    doReq(0, 1'b0, SZ_BYTE, 1'b0, 'h13, 32'h0, r);  checkVal("t2_lbu", 64'(r), 64'h0_00000080);
    doReq(0, 1'b0, SZ_WORD, 1'b0, 'h10, 32'h0, r);  checkVal("t2_lw", 64'(r), 64'h0_80ADBEEF);
    doReq(0, 1'b1, SZ_HALF, 1'b0, 'h12, 32'h1234, r);
    doReq(0, 1'b0, SZ_HALF, 1'b1, 'h12, 32'h0, r);  checkVal("t3_lh", 64'(r), 64'h0_00001234);
    doReq(0, 1'b0, SZ_WORD, 1'b0, 'h10, 32'h0, r);  checkVal("t3_lw", 64'(r), 64'h0_1234BEEF);
    doReq(0, 1'b1, SZ_HALF, 1'b0, 'h11, 32'hFFFF, r); checkVal("t3_sh_err", 64'(r), 64'h1_00000000);
    doReq(0, 1'b0, SZ_WORD, 1'b0, 'h10, 32'h0, r);  checkVal("t3_unchanged", 64'(r), 64'h0_1234BEEF);

    // Three wait states with req_valid held high across two requests.
    doReq(1, 1'b1, SZ_WORD, 1'b0, 'h30, 32'hCAFEF00D, r);
    @(negedge clk);
    reqWe[1] = 1'b0; reqSize[1] = SZ_WORD; reqSigned[1] = 1'b0; reqAddr[1] = 'h30;
    reqValid[1] = 1'b1;
    checkVal("t4_ready_c0", 64'(reqReady[1]), 64'd1);
    @(posedge clk);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checkVal($sformatf("t4_ready_c%0d", c), 64'(reqReady[1]), 64'(c == 5));
      checkVal($sformatf("t4_valid_c%0d", c), 64'(rspValid[1]), 64'(c == 4));
      if (c == 4) checkVal("t4_rdata", 64'(rspRdata[1]), 64'hCAFEF00D);
    end
    @(posedge clk);
    #1;
    reqValid[1] = 1'b0;
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!rspValid[1] && n < 40);
      checkVal("t4_second_lat", 64'(n), 64'(LAT1 + 1));
      checkVal("t4_second_rdata", 64'(rspRdata[1]), 64'hCAFEF00D);
      @(negedge clk);
    end

    // Reset while a store waits: outputs clear at once, store is lost.
    doReq(1, 1'b1, SZ_WORD, 1'b0, 'h24, 32'h11223344, r);
    doReq(1, 1'b0, SZ_WORD, 1'b0, 'h24, 32'h0, r);  checkVal("t5_pre", 64'(r), 64'h0_11223344);
    @(negedge clk);
    reqWe[1] = 1'b1; reqSize[1] = SZ_WORD; reqAddr[1] = 'h20; reqWdata[1] = 32'h55;
    reqValid[1] = 1'b1;
    @(posedge clk);
    #1;
    reqValid[1] = 1'b0;
    @(negedge clk);
    checkVal("t5_in_wait", 64'(dbg[1]), 64'(WAIT));
    rstN[1] = 1'b0;
    #1;
    checkResetOutputs(1, "t5_reset");
    repeat (4) @(negedge clk);
    rstN[1] = 1'b1;
    doReq(1, 1'b0, SZ_WORD, 1'b0, 'h20, 32'h0, r);  checkVal("t5_lost", 64'(r), 64'h0_00000000);
    doReq(1, 1'b0, SZ_WORD, 1'b0, 'h24, 32'h0, r);  checkVal("t5_kept", 64'(r), 64'h0_11223344);

    // Top word and the reserved size on both instances.
    for (int d = 0; d < 2; d++) begin
      doReq(d, 1'b1, SZ_WORD, 1'b0, topAddr, 32'hA5A5A5A5, r);
      doReq(d, 1'b0, SZ_WORD, 1'b0, topAddr, 32'h0, r);   checkVal("t6_top", 64'(r), 64'h0_A5A5A5A5);
      doReq(d, 1'b0, 2'd3, 1'b0, topAddr, 32'h0, r);      checkVal("t6_size3", 64'(r), 64'h1_00000000);
    end

    // Random traffic over a small window plus the top word.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 150; i++) begin
        int sel;
        logic [1:0] sz;
        logic [AW-1:0] w;
        sel = $urandom_range(0, 9);
        sz  = (sel == 9) ? 2'd3 : 2'(sel % 3);
        w   = ($urandom_range(0, 15) == 0) ? AW'(DEPTH - 1) : AW'($urandom_range(0, 15));
        doReq(d, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
              {w, 2'($urandom_range(0, 3))}, $urandom, r);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
